ddr3_test_monitor: RTL and testbench

- Passive observer placed directly downstream of the DDR3 read/write test engine.
- Taps the MIG app-interface handshake signals and the engine's pass/fail outputs without driving either.
- Accumulates statistics and measures read latency. Flags stalled reads with a watchdog, drives board LEDs, and exposes the results through a small registered read port for the host register block.

---
 rtl/ddr3_test_monitor.sv | 119 +++++++++++
 tb/tb_ddr3_test_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_test_monitor.sv
// Passive monitor for the DDR3 test engine: taps MIG app handshakes, counts traffic,
// measures read latency, watches for stalled reads and drives LEDs plus a register port.
module ddr3_test_monitor #(
    parameter int pTIMEOUT  = 4096,
    parameter int pHB_BITS  = 24,
    parameter int pOUT_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        active,
    input  logic        init_calib_complete,
    input  logic        pass,
    input  logic        fail,
    input  logic        app_en,
    input  logic [2:0]  app_cmd,
    input  logic        app_rdy,
    input  logic        app_rd_data_valid,
    input  logic        clear,
    input  logic [2:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        led_pass,
    output logic        led_fail,
    output logic        led_heartbeat,
    output logic        timeout
);
    localparam int WD_W = $clog2(pTIMEOUT) + 1;
    localparam logic [WD_W-1:0]      WD_LAST = WD_W'(pTIMEOUT - 1);
    localparam logic [pOUT_BITS-1:0] OUT_ONE = pOUT_BITS'(1);

    logic                 acc, rd_acc, wr_acc, run, rdv;
    logic [31:0]          wr_cnt, rd_cmd_cnt, rdv_cnt, cyc, fail_ts;
    logic [15:0]          lat_timer, last_lat, max_lat;
    logic [pOUT_BITS-1:0] outstanding;
    logic [WD_W-1:0]      wd_cnt;
    logic [pHB_BITS-1:0]  hb_cnt;
    logic                 ovf, unf, pass_seen, fail_sticky;
    logic [31:0]          reg_next;

    assign acc    = app_en & app_rdy;
    assign rd_acc = acc & (app_cmd == 3'b001);
    assign wr_acc = acc & (app_cmd == 3'b000);
    assign rdv    = app_rd_data_valid;
    assign run    = active & init_calib_complete;

    always_comb begin
        reg_next = '0;
        case (reg_addr)
            3'd0: reg_next = {24'b0, unf, ovf, timeout, fail_sticky, pass_seen,
                              fail, init_calib_complete, active};
            3'd1: reg_next = wr_cnt;
            3'd2: reg_next = rd_cmd_cnt;
            3'd3: reg_next = rdv_cnt;
            3'd4: reg_next = {max_lat, last_lat};
            3'd5: reg_next = fail_ts;
            3'd6: reg_next = cyc;
            3'd7: reg_next = {16'hD3A7, {(16-pOUT_BITS){1'b0}}, outstanding};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0; rd_cmd_cnt <= '0; rdv_cnt <= '0; cyc <= '0; fail_ts <= '0;
            lat_timer <= '0; last_lat <= '0; max_lat <= '0; outstanding <= '0;
            wd_cnt <= '0; hb_cnt <= '0; ovf <= 1'b0; unf <= 1'b0;
            pass_seen <= 1'b0; fail_sticky <= 1'b0; timeout <= 1'b0;
            led_pass <= 1'b0; led_fail <= 1'b0; led_heartbeat <= 1'b0; reg_data <= '0;
        end else if (clear) begin
            wr_cnt <= '0; rd_cmd_cnt <= '0; rdv_cnt <= '0; cyc <= '0; fail_ts <= '0;
            lat_timer <= '0; last_lat <= '0; max_lat <= '0; outstanding <= '0;
            wd_cnt <= '0; hb_cnt <= '0; ovf <= 1'b0; unf <= 1'b0;
            pass_seen <= 1'b0; fail_sticky <= 1'b0; timeout <= 1'b0;
            led_pass <= 1'b0; led_fail <= 1'b0; led_heartbeat <= 1'b0; reg_data <= '0;
        end else begin
            if (wr_acc && wr_cnt != '1)     wr_cnt     <= wr_cnt + 32'd1;
            if (rd_acc && rd_cmd_cnt != '1) rd_cmd_cnt <= rd_cmd_cnt + 32'd1;
            if (rdv && rdv_cnt != '1)       rdv_cnt    <= rdv_cnt + 32'd1;

            // a same-cycle accept and return cancel out and never flag ovf/unf
            if (rd_acc && !rdv) begin
                if (outstanding == '1) ovf <= 1'b1;
                else                   outstanding <= outstanding + OUT_ONE;
            end else if (rdv && !rd_acc) begin
                if (outstanding == '0) unf <= 1'b1;
                else                   outstanding <= outstanding - OUT_ONE;
            end

            // the timer spans a whole busy period: first accept until the queue drains
            if (rdv && outstanding == OUT_ONE) begin
                last_lat <= lat_timer;
                if (lat_timer > max_lat) max_lat <= lat_timer;
            end
            if (rd_acc && (outstanding == '0 || (outstanding == OUT_ONE && rdv)))
                lat_timer <= 16'd1;
            else if (outstanding != '0 && lat_timer != '1)
                lat_timer <= lat_timer + 16'd1;

            if (rdv || outstanding == '0) wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)   wd_cnt <= wd_cnt + WD_W'(1);
            if (outstanding != '0 && wd_cnt == WD_LAST) timeout <= 1'b1;

            if (run) begin
                if (cyc != '1) cyc <= cyc + 32'd1;
                hb_cnt <= hb_cnt + pHB_BITS'(1);
                if (hb_cnt == '1) led_heartbeat <= ~led_heartbeat;
            end

            if (pass) pass_seen <= 1'b1;
            if (fail && !fail_sticky) begin
                fail_sticky <= 1'b1;
                fail_ts     <= cyc;
            end

            led_pass <= pass_seen & ~fail_sticky & ~timeout;
            led_fail <= fail_sticky | timeout;
            reg_data <= reg_next;
        end
    end
endmodule

// File: tb/tb_ddr3_test_monitor.sv
// Bench for ddr3_test_monitor: directed scenarios then random traffic, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_ddr3_test_monitor;
    localparam int TO = 16;
    localparam int HB = 4;
    localparam int OB = 2;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        active = 1'b0, init_calib_complete = 1'b0, pass = 1'b0, fail = 1'b0;
    logic        app_en = 1'b0, app_rdy = 1'b0, app_rd_data_valid = 1'b0, clear = 1'b0;
    logic [2:0]  app_cmd = 3'b000, reg_addr = 3'd0;
    logic [31:0] reg_data;
    logic        led_pass, led_fail, led_heartbeat, timeout;

    ddr3_test_monitor #(.pTIMEOUT(TO), .pHB_BITS(HB), .pOUT_BITS(OB)) dut (
        .clk(clk), .reset_n(reset_n), .active(active), .init_calib_complete(init_calib_complete),
        .pass(pass), .fail(fail), .app_en(app_en), .app_cmd(app_cmd), .app_rdy(app_rdy),
        .app_rd_data_valid(app_rd_data_valid), .clear(clear), .reg_addr(reg_addr),
        .reg_data(reg_data), .led_pass(led_pass), .led_fail(led_fail),
        .led_heartbeat(led_heartbeat), .timeout(timeout));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: counts plus timestamps of busy-period start and last watchdog kick
    longint now = 0;
    longint m_wr, m_rd, m_rdv, m_cyc, m_fts, m_hbn, m_bstart, m_wdmark;
    int     m_out, m_last, m_max;
    bit     m_to, m_ovf, m_unf, m_ps, m_fs, m_lp, m_lf;
    logic [31:0] m_reg;

    function automatic longint inc32(longint x);
        return (x >= 64'hFFFF_FFFF) ? x : x + 1;
    endfunction

    task automatic model_zero(longint mark);
        m_wr = 0; m_rd = 0; m_rdv = 0; m_cyc = 0; m_fts = 0; m_hbn = 0;
        m_out = 0; m_last = 0; m_max = 0;
        m_to = 0; m_ovf = 0; m_unf = 0; m_ps = 0; m_fs = 0; m_lp = 0; m_lf = 0;
        m_reg = '0; m_bstart = now; m_wdmark = mark;
    endtask

    task automatic model_tick();
        bit acc, rdacc, wracc, v, lp_n, lf_n;
        longint d;
        logic [31:0] r;
        acc = app_en && app_rdy;
        rdacc = acc && app_cmd == 3'b001;
        wracc = acc && app_cmd == 3'b000;
        v = app_rd_data_valid;
        if (clear) begin
            model_zero(now);
            return;
        end
        case (reg_addr)
            3'd0: r = {24'b0, m_unf, m_ovf, m_to, m_fs, m_ps, fail, init_calib_complete, active};
            3'd1: r = m_wr[31:0];
            3'd2: r = m_rd[31:0];
            3'd3: r = m_rdv[31:0];
            3'd4: r = {m_max[15:0], m_last[15:0]};
            3'd5: r = m_fts[31:0];
            3'd6: r = m_cyc[31:0];
            default: r = 32'hD3A7_0000 | 32'(m_out);
        endcase
        lp_n = m_ps && !m_fs && !m_to;
        lf_n = m_fs || m_to;
        if (m_out != 0 && now - m_wdmark >= TO) m_to = 1;
        if (v && m_out == 1) begin
            d = now - m_bstart;
            if (d > 65535) d = 65535;
            m_last = int'(d);
            if (m_last > m_max) m_max = m_last;
        end
        if (rdacc && (m_out == 0 || (m_out == 1 && v))) m_bstart = now;
        if (v || m_out == 0) m_wdmark = now;
        if (rdacc && !v) begin
            if (m_out == (1 << OB) - 1) m_ovf = 1; else m_out++;
        end else if (v && !rdacc) begin
            if (m_out == 0) m_unf = 1; else m_out--;
        end
        if (wracc) m_wr = inc32(m_wr);
        if (rdacc) m_rd = inc32(m_rd);
        if (v)     m_rdv = inc32(m_rdv);
        if (fail && !m_fs) begin m_fs = 1; m_fts = m_cyc; end
        if (pass) m_ps = 1;
        if (active && init_calib_complete) begin m_cyc = inc32(m_cyc); m_hbn++; end
        m_lp = lp_n; m_lf = lf_n; m_reg = r;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        now++;
        #1;
        chk("reg_data", reg_data, m_reg);
        chk("led_pass", 32'(led_pass), 32'(m_lp));
        chk("led_fail", 32'(led_fail), 32'(m_lf));
        chk("led_heartbeat", 32'(led_heartbeat), 32'((m_hbn >> HB) & 1));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic idle();
        app_en = 0; app_rd_data_valid = 0; pass = 0; fail = 0; clear = 0;
    endtask

    task automatic rd_chk(string tag, logic [2:0] a, logic [31:0] exp);
        idle();
        reg_addr = a;
        step();
        chk(tag, reg_data, exp);
    endtask

    task automatic reset_pulse();
        reset_n = 0;
        #1;
        chk("rst_reg", reg_data, 0);
        chk("rst_leds", 32'({led_pass, led_fail, led_heartbeat}), 0);
        chk("rst_timeout", 32'(timeout), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_zero(now - 1);
    endtask

    initial begin
        #2;
        reset_pulse();
        for (int a = 0; a < 8; a++) rd_chk("rst_regmap", 3'(a), (a == 7) ? 32'hD3A7_0000 : 32'h0);

        // 64 writes, then one read returned 20 cycles after accept
        active = 1; init_calib_complete = 1; app_rdy = 1;
        app_en = 1; app_cmd = 3'b000;
        repeat (64) step();
        app_cmd = 3'b001; step();
        app_en = 0; repeat (19) step();
        app_rd_data_valid = 1; step();
        rd_chk("wr_cnt", 3'd1, 32'd64);
        rd_chk("rd_cmd_cnt", 3'd2, 32'd1);
        rd_chk("rdv_cnt", 3'd3, 32'd1);
        rd_chk("lat_20", 3'd4, 32'h0014_0014);
        rd_chk("out_drained", 3'd7, 32'hD3A7_0000);

        // overlapping reads: accepts at 0 and 3, returns at 10 and 12
        clear = 1; step(); idle();
        for (int t = 0; t <= 12; t++) begin
            app_en = (t == 0 || t == 3); app_cmd = 3'b001;
            app_rd_data_valid = (t == 10 || t == 12);
            step();
        end
        rd_chk("lat_overlap", 3'd4, 32'h000C_000C);
        rd_chk("status_no_unf", 3'd0, 32'h0000_0003);

        // stalled read trips the watchdog; clear wipes everything
        clear = 1; step(); idle();
        app_en = 1; app_cmd = 3'b001; step();
        idle(); repeat (20) step();
        chk("wd_timeout", 32'(timeout), 1);
        chk("wd_led_fail", 32'(led_fail), 1);
        active = 0;
        clear = 1; step(); idle();
        chk("clr_timeout", 32'(timeout), 0);
        for (int a = 1; a < 7; a++) rd_chk("clr_regs", 3'(a), 32'h0);
        rd_chk("clr_out", 3'd7, 32'hD3A7_0000);

        // pass then two fails: timestamp of the first fail is kept
        active = 1;
        for (int i = 0; i <= 250; i++) begin
            pass = (i == 5); fail = (i == 100 || i == 200);
            step();
        end
        rd_chk("fail_ts", 3'd5, 32'd100);
        chk("fail_led_pass", 32'(led_pass), 0);
        chk("fail_led_fail", 32'(led_fail), 1);

        // underflow, then accept+return at depth 2
        clear = 1; step(); idle();
        app_rd_data_valid = 1; step();
        rd_chk("unf_status", 3'd0, 32'h0000_0083);
        rd_chk("unf_rdv", 3'd3, 32'd1);
        rd_chk("unf_out", 3'd7, 32'hD3A7_0000);
        app_en = 1; app_cmd = 3'b001; repeat (2) step();
        app_rd_data_valid = 1; step();
        rd_chk("both_out", 3'd7, 32'hD3A7_0002);

        // random traffic with occasional clear and a mid-run reset
        for (int blk = 0; blk < 6; blk++) begin
            int vp;
            vp = int'($urandom_range(5, 70));
            for (int i = 0; i < 500; i++) begin
                app_en = ($urandom_range(0, 1) == 1);
                app_rdy = ($urandom_range(0, 3) != 0);
                app_cmd = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7))
                                                      : 3'($urandom_range(0, 1));
                app_rd_data_valid = ($urandom_range(0, 99) < vp);
                pass = ($urandom_range(0, 199) == 0);
                fail = ($urandom_range(0, 399) == 0);
                clear = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0) active = ~active;
                init_calib_complete = ($urandom_range(0, 99) != 0);
                reg_addr = 3'($urandom_range(0, 7));
                step();
            end
            if (blk == 2) begin
                app_en = 1; app_rdy = 1; app_cmd = 3'b001; app_rd_data_valid = 0; clear = 0;
                step();
                reset_pulse();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
